rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Sits between data_io and sdram on the ROM download path.
- Turns the ioctl byte stream (index 0) into 16-bit SDRAM write requests on the two SDRAM ports:
  - CPU program region goes to port1.
  - Graphics region goes to port2, with an offset.
- Uses the sdram toggle req/ack handshake, and buffers writes in a small FIFO.
- Raises rom_loaded once the last byte is committed, which gates the core reset.

Parameters:
FIFO_DEPTH, 4, number of pending word writes buffered (power of 2, >=2)
GFX_OFFSET, 23'h8000, word offset subtracted from port2 addresses

Ports:
clk_sys      in   1   system clock (same clock as sdram)
reset        in   1   synchronous, active-high
ioctl_downl  in   1   download active
ioctl_wr     in   1   byte strobe (level; rising edge = new byte)
ioctl_index  in   8   download index; only 0 is processed
ioctl_addr   in   25  byte address
ioctl_dout   in   8   byte data
port1_req    out  1   toggle request, CPU region
port1_ack    in   1   toggle ack from sdram
port1_a      out  23  word address
port1_ds     out  2   byte enables {hi,lo}
port1_d      out  16  write data
port2_req    out  1   toggle request, gfx region
port2_ack    in   1   toggle ack
port2_a      out  23  word address (addr[23:1]-GFX_OFFSET)
port2_ds     out  2   byte enables
port2_d      out  16  write data
busy         out  1   download active, or FIFO non-empty, or request outstanding
rom_loaded   out  1   sticky: full image committed
ovf          out  1   sticky: byte dropped because FIFO was full

Behaviour:
- Reset values:
  - All outputs 0; port*_a/ds/d are 0.
  - FIFO empty, packer empty, issuer FSM in IDLE.
  - Reset mid-download discards all state. Any in-flight request is abandoned; sdram is reset together with this block.
- Byte capture:
  - A byte is accepted on the rising edge of ioctl_wr, while ioctl_downl=1 and ioctl_index=0.
  - Capture happens 1 cycle after the edge.
  - ioctl_wr edges are guaranteed >=4 clk apart.
- Packer: holds one pending word {pa, lo byte, lo_valid}.
  - Even byte (addr[0]=0):
    - If a pending word exists, flush it first: ds=01.
    - Then store the byte as the pending lo byte, with pa=addr[23:1].
  - Odd byte, pending with same pa: push the full word, d={byte,lo}, ds=11. Pending is then cleared.
  - Odd byte, no pending or a different pa:
    - Flush any pending word (ds=01).
    - Push d={byte,8'h00}, ds=10.
  - Flush has priority: at most one push per cycle. The second push follows on the next cycle.
  - Falling edge of ioctl_downl flushes any pending word (ds=01).
- Region decode on push:
  - addr[23:16]==0: entry tagged port1, a=addr[23:1].
  - addr[23:16]==1: entry tagged port2, a=addr[23:1]-GFX_OFFSET, mod 2^23.
  - Otherwise the word is discarded; no push, no ovf.
- FIFO:
  - Entry = {port, a[22:0], ds[1:0], d[15:0]}.
  - A push while full drops the entry and sets ovf.
  - ovf is cleared on the rising edge of ioctl_downl.
  - Simultaneous push and pop while full is accepted.
- Issuer FSM, one request outstanding at a time:
  - IDLE: if FIFO not empty, drive the head entry onto the selected port's a/ds/d, toggle that port's req, go to WAIT. The req toggle appears on the cycle after the entry reaches the FIFO head.
  - WAIT: when the selected port's ack == req, pop the FIFO and return to IDLE.
  - Output a/ds/d are held stable from the toggle until the pop.
  - The unselected port's outputs are unchanged.
- rom_loaded:
  - Set on the first cycle where a download has ended, FIFO is empty, the packer is empty and the FSM is IDLE.
  - Stays set until reset.
  - A new download does not clear it.
- busy is combinational from the internal state listed in its port description.

Optional Feature:
LOADER_CHECKSUM_EN
- With it: extra output checksum[15:0], a 16-bit wrapping sum of every accepted byte (index 0).
  - Cleared on the rising edge of ioctl_downl.
  - Frozen once the download ends.
- Without it: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Bytes 0x11@0, 0x22@1 with ack echoing req after 3 clk -> one port1 write, a=0, ds=11, d=0x2211; port1_req toggles once; rom_loaded=1 after downl falls.
- Bytes 0xAA@0x10000, 0xBB@0x10001 -> port2 write, a=0x0000 (0x8000-GFX_OFFSET), d=0xBBAA, ds=11; port1_req unchanged.
- Byte 0x5A@4 then 0x77@9, then downl falls -> port1 writes {a=2, ds=01, d=0x005A} then {a=4, ds=10, d=0x7700}, in order.
- ack held stuck for 40 clk while 12 bytes stream -> FIFO fills, ovf=1, no req toggle while in WAIT; after ack, remaining entries drain; ovf clears at next download start.
- Byte at 0x20000 -> no request, no ovf; index 0xFF bytes ignored entirely.
- Reset asserted while in WAIT -> next cycle: req=0, busy=0, rom_loaded=0, FIFO empty; with LOADER_CHECKSUM_EN, bytes 0xFF,0x02 -> checksum=0x0101.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: ROM download path between data_io and sdram.
//
// Packs the ioctl byte stream (index 0) into 16-bit word writes. Words in the
// CPU region (addr[23:16]==0) go to port1; words in the graphics region
// (addr[23:16]==1) go to port2 with GFX_OFFSET subtracted from the word
// address. Any other address is discarded. Words wait in a small FIFO and are
// issued one at a time over the sdram toggle req/ack handshake.
//
// Ports:
//   clk_sys, reset            system clock, synchronous active-high reset
//   ioctl_downl/wr/index/     data_io download interface (wr is a level strobe,
//   ioctl_addr/dout           a rising edge marks a new byte)
//   port1_req/ack/a/ds/d      sdram port for the CPU region
//   port2_req/ack/a/ds/d      sdram port for the graphics region
//   busy                      download active, FIFO non-empty or request out
//   rom_loaded                sticky, full image committed
//   ovf                       sticky, byte dropped on a full FIFO
//   checksum                  only with LOADER_CHECKSUM_EN: 16-bit wrapping sum
//                             of accepted bytes of the current download
//
// Optional feature macro: LOADER_CHECKSUM_EN
module rom_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [22:0] GFX_OFFSET = 23'h8000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        busy,
  output logic        rom_loaded,
  output logic        ovf
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        port;  // 0 = port1, 1 = port2
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Edge detection and byte capture
  logic        wr_q, downl_q;
  logic        downl_rise, downl_fall, byte_stb;
  logic        cap_v;
  logic [23:0] cap_addr;
  logic [7:0]  cap_d;

  // Packer: one pending low byte
  logic        pend_v;
  logic [22:0] pend_pa;
  logic [7:0]  pend_lo;
  logic        end_flush;
  logic        dl_seen;

  logic unused_addr_msb;
  assign unused_addr_msb = ioctl_addr[24];

  assign downl_rise = ioctl_downl & ~downl_q;
  assign downl_fall = ~ioctl_downl & downl_q;
  assign byte_stb   = ioctl_wr & ~wr_q & ioctl_downl & (ioctl_index == 8'd0);

  // Word produced by the packer this cycle, before region decode.
  logic        emit;
  logic [22:0] emit_pa;
  logic [1:0]  emit_ds;
  logic [15:0] emit_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    emit    = 1'b0;
    emit_pa = pend_pa;
    emit_ds = 2'b01;
    emit_d  = {8'h00, pend_lo};
    if (cap_v) begin
      if (cap_addr[0] && pend_v && (pend_pa == cap_addr[23:1])) begin
        emit    = 1'b1;
        emit_ds = 2'b11;
        emit_d  = {cap_d, pend_lo};
      end else if (pend_v) begin
        emit = 1'b1;  // flush the pending low byte first
      end else if (cap_addr[0]) begin
        emit    = 1'b1;
        emit_pa = cap_addr[23:1];
        emit_ds = 2'b10;
        emit_d  = {cap_d, 8'h00};
      end
    end else if (end_flush && pend_v) begin
      emit = 1'b1;
    end
  end

  // Region decode: word address bits [22:15] are byte address bits [23:16].
  entry_t push_e;
  logic   push;
  assign push        = emit && (emit_pa[22:16] == 7'd0);
  assign push_e.port = emit_pa[15];
  assign push_e.a    = emit_pa[15] ? (emit_pa - GFX_OFFSET) : emit_pa;
  assign push_e.ds   = emit_ds;
  assign push_e.d    = emit_d;

  // FIFO
  entry_t      mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, push_ok;
  entry_t      head;

  state_t state;
  logic   sel;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = (state == S_WAIT) &&
                   (sel ? (port2_ack == port2_req) : (port1_ack == port1_req));
  assign push_ok = push && (!full || pop);
  assign head    = mem[rptr[AW-1:0]];
  assign busy    = ioctl_downl | ~empty | (state == S_WAIT);

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_e;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q       <= 1'b0;
      downl_q    <= 1'b0;
      cap_v      <= 1'b0;
      cap_addr   <= '0;
      cap_d      <= '0;
      pend_v     <= 1'b0;
      pend_pa    <= '0;
      pend_lo    <= '0;
      end_flush  <= 1'b0;
      dl_seen    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      ovf        <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;

      if (cap_v) begin
        if (!cap_addr[0]) begin
          pend_v  <= 1'b1;
          pend_pa <= cap_addr[23:1];
          pend_lo <= cap_d;
          cap_v   <= 1'b0;
        end else if (pend_v && (pend_pa == cap_addr[23:1])) begin
          pend_v <= 1'b0;
          cap_v  <= 1'b0;
        end else if (pend_v) begin
          // Flush went out this cycle; the odd byte is retried next cycle
          // against an empty packer.
          pend_v <= 1'b0;
        end else begin
          cap_v <= 1'b0;
        end
      end else if (end_flush) begin
        pend_v    <= 1'b0;
        end_flush <= 1'b0;
      end
      if (downl_fall) end_flush <= 1'b1;
      if (byte_stb) begin
        cap_v    <= 1'b1;
        cap_addr <= ioctl_addr[23:0];
        cap_d    <= ioctl_dout;
      end

      if (ioctl_downl && (ioctl_index == 8'd0)) dl_seen <= 1'b1;

      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;

      if (downl_rise)                 ovf <= 1'b0;
      else if (push && full && !pop)  ovf <= 1'b1;

      if (dl_seen && !ioctl_downl && empty && !pend_v && !cap_v &&
          !end_flush && (state == S_IDLE))
        rom_loaded <= 1'b1;
    end
  end

  // Issuer FSM: one outstanding request, outputs held until the pop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      sel       <= 1'b0;
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          if (head.port) begin
            port2_a   <= head.a;
            port2_ds  <= head.ds;
            port2_d   <= head.d;
            port2_req <= ~port2_req;
          end else begin
            port1_a   <= head.a;
            port1_ds  <= head.ds;
            port1_d   <= head.d;
            port1_req <= ~port1_req;
          end
          sel   <= head.port;
          state <= S_WAIT;
        end
        S_WAIT: if (pop) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset)           checksum <= '0;
    else if (downl_rise) checksum <= byte_stb ? {8'h00, ioctl_dout} : 16'h0000;
    else if (byte_stb)   checksum <= checksum + {8'h00, ioctl_dout};
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: a transaction-level model turns each
// accepted byte into expected word writes per port; a monitor compares every
// request toggle and the held port outputs against it each cycle.
module tb_rom_loader;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [22:0] GFX_OFFSET = 23'h8000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_downl, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        port1_req, port1_ack, port2_req, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        busy, rom_loaded, ovf;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_loader #(.FIFO_DEPTH(FIFO_DEPTH), .GFX_OFFSET(GFX_OFFSET)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .busy(busy), .rom_loaded(rom_loaded), .ovf(ovf)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  wr_t         exp1[$], exp2[$];
  wr_t         log1[$];
  logic        m_pv;
  logic [22:0] m_pa;
  logic [7:0]  m_lo;
  logic [15:0] m_sum;

  task automatic m_emit(input logic [22:0] pa, input logic [1:0] ds, input logic [15:0] d);
    // pa[22:15] is byte address [23:16]
    if (pa[22:15] == 8'd0)      exp1.push_back('{pa, ds, d});
    else if (pa[22:15] == 8'd1) exp2.push_back('{23'(pa - GFX_OFFSET), ds, d});
  endtask

  task automatic m_byte(input logic [24:0] addr, input logic [7:0] b);
    logic [22:0] pa;
    pa = addr[23:1];
    m_sum = m_sum + 16'(b);
    if (!addr[0]) begin
      if (m_pv) m_emit(m_pa, 2'b01, {8'h00, m_lo});
      m_pv = 1'b1; m_pa = pa; m_lo = b;
    end else if (m_pv && m_pa == pa) begin
      m_emit(pa, 2'b11, {b, m_lo});
      m_pv = 1'b0;
    end else begin
      if (m_pv) m_emit(m_pa, 2'b01, {8'h00, m_lo});
      m_pv = 1'b0;
      m_emit(pa, 2'b10, {b, 8'h00});
    end
  endtask

  // ---------------- sdram responder ----------------
  logic stall = 1'b0;
  int   lat = 3;
  int   r_c1 = 0, r_c2 = 0;

  initial begin
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        port1_ack = 1'b0; port2_ack = 1'b0; r_c1 = 0; r_c2 = 0;
      end else begin
        if (port1_req != port1_ack && !stall) begin
          r_c1++;
          if (r_c1 >= lat) begin port1_ack = port1_req; r_c1 = 0; end
        end
        if (port2_req != port2_ack && !stall) begin
          r_c2++;
          if (r_c2 >= lat) begin port2_ack = port2_req; r_c2 = 0; end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic pr1 = 1'b0, pr2 = 1'b0;
  wr_t  h1 = '0, h2 = '0, w;
  int   tog1 = 0, tog2 = 0;

  initial begin
    forever begin
      @(posedge clk_sys); #1;
      if (reset) begin
        pr1 = port1_req; pr2 = port2_req; h1 = '0; h2 = '0;
        continue;
      end
      if (port1_req != pr1) begin
        tog1++;
        check("p1 prev acked", port1_ack, pr1);
        check("p2 idle on p1 issue", port2_req, port2_ack);
        if (exp1.size() == 0) check("p1 unexpected write", {port1_a, port1_ds, port1_d}, 64'hDEAD);
        else begin
          w = exp1.pop_front();
          check("p1 write", {port1_a, port1_ds, port1_d}, w);
        end
        h1 = '{port1_a, port1_ds, port1_d};
        log1.push_back(h1);
      end else begin
        check("p1 hold", {port1_a, port1_ds, port1_d}, h1);
      end
      if (port2_req != pr2) begin
        tog2++;
        check("p2 prev acked", port2_ack, pr2);
        check("p1 idle on p2 issue", port1_req, port1_ack);
        if (exp2.size() == 0) check("p2 unexpected write", {port2_a, port2_ds, port2_d}, 64'hDEAD);
        else begin
          w = exp2.pop_front();
          check("p2 write", {port2_a, port2_ds, port2_d}, w);
        end
        h2 = '{port2_a, port2_ds, port2_d};
      end else begin
        check("p2 hold", {port2_a, port2_ds, port2_d}, h2);
      end
      pr1 = port1_req;
      pr2 = port2_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr,
                           input logic [7:0] data, input int gap);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
    if (ioctl_downl && idx == 8'd0) m_byte(addr, data);
    repeat (3) @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (gap - 3) @(negedge clk_sys);
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_downl = 1'b1; ioctl_index = 8'd0;
    m_pv = 1'b0; m_sum = 16'h0000;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (8) @(negedge clk_sys);
    while (busy && n < 1000) begin @(negedge clk_sys); n++; end
    check({name, " idle"}, busy, 0);
    check({name, " p1 drained"}, exp1.size(), 0);
    check({name, " p2 drained"}, exp2.size(), 0);
  endtask

  task automatic end_dl(input string name);
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    if (m_pv) m_emit(m_pa, 2'b01, {8'h00, m_lo});
    m_pv = 1'b0;
    wait_idle(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int n;
    logic [24:0] cur;
    logic [1:0]  rg;
    logic [7:0]  idx;

    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
    m_pv = 1'b0; m_pa = '0; m_lo = '0; m_sum = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst port1_req", port1_req, 0);
    check("rst port2_req", port2_req, 0);
    check("rst outputs", {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d}, 0);
    check("rst busy/loaded/ovf", {busy, rom_loaded, ovf}, 0);
    @(negedge clk_sys);
    reset = 1'b0;

    // T1: one full CPU word
    lat = 3;
    start_dl();
    send_byte(8'd0, 25'h0, 8'h11, 6);
    send_byte(8'd0, 25'h1, 8'h22, 6);
    end_dl("t1");
    check("t1 toggles", tog1, 1);
    check("t1 word", {port1_a, port1_ds, port1_d}, {23'd0, 2'b11, 16'h2211});
    n = 0;
    while (!rom_loaded && n < 20) begin @(negedge clk_sys); n++; end
    check("t1 rom_loaded", rom_loaded, 1);

    // T2: graphics word with offset
    start_dl();
    send_byte(8'd0, 25'h10000, 8'hAA, 6);
    send_byte(8'd0, 25'h10001, 8'hBB, 6);
    end_dl("t2");
    check("t2 p2 toggles", tog2, 1);
    check("t2 p1 toggles", tog1, 1);
    check("t2 word", {port2_a, port2_ds, port2_d}, {23'd0, 2'b11, 16'hBBAA});

    // T3: isolated low then isolated high byte
    start_dl();
    send_byte(8'd0, 25'h4, 8'h5A, 6);
    send_byte(8'd0, 25'h9, 8'h77, 6);
    end_dl("t3");
    check("t3 toggles", tog1, 3);
    check("t3 first", log1[log1.size()-2], {23'd2, 2'b01, 16'h005A});
    check("t3 second", log1[log1.size()-1], {23'd4, 2'b10, 16'h7700});

    // T4: ack stalled, FIFO overflows
    t0 = tog1;
    stall = 1'b1;
    start_dl();
    for (int i = 0; i < 12; i++) send_byte(8'd0, 25'h100 + 25'(i), 8'($urandom), 6);
    repeat (10) @(negedge clk_sys);
    check("t4 ovf set", ovf, 1);
    check("t4 no toggle in wait", tog1, t0 + 1);
    // One entry is issued (and already matched); FIFO_DEPTH-1 more fit behind it.
    while (exp1.size() > FIFO_DEPTH - 1) void'(exp1.pop_back());
    stall = 1'b0;
    end_dl("t4");
    check("t4 drained count", tog1, t0 + FIFO_DEPTH);
    check("t4 ovf sticky", ovf, 1);

    // T5: ovf clears on new download; out-of-range and foreign index ignored
    t0 = tog1;
    start_dl();
    check("t5 ovf cleared", ovf, 0);
    send_byte(8'hFF, 25'h0, 8'h99, 6);
    send_byte(8'hFF, 25'h1, 8'h98, 6);
    send_byte(8'd0, 25'h20000, 8'h33, 6);
    end_dl("t5");
    check("t5 p1 toggles", tog1, t0);
    check("t5 p2 toggles", tog2, 1);
    check("t5 ovf", ovf, 0);

    // T6: randomized stream
    lat = 2;
    start_dl();
    cur = 25'h0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 65) cur = cur + 25'd1;
      else begin
        rg  = 2'($urandom_range(0, 2));
        cur = {1'b0, 6'd0, rg, 16'($urandom)};
      end
      idx = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'h00;
      send_byte(idx, cur, 8'($urandom), 10);
    end
    end_dl("t6");
    check("t6 ovf", ovf, 0);
`ifdef LOADER_CHECKSUM_EN
    check("t6 checksum", checksum, m_sum);
`endif

    // T7: reset while a request is outstanding
    lat = 3;
    stall = 1'b1;
    start_dl();
    send_byte(8'd0, 25'h40, 8'h12, 6);
    send_byte(8'd0, 25'h41, 8'h34, 6);
    repeat (3) @(negedge clk_sys);
    check("t7 busy before reset", busy, 1);
    ioctl_downl = 1'b0;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("t7 reqs", {port1_req, port2_req}, 0);
    check("t7 busy", busy, 0);
    check("t7 rom_loaded", rom_loaded, 0);
    exp1.delete(); exp2.delete(); m_pv = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    stall = 1'b0;
    start_dl();
    send_byte(8'd0, 25'h0, 8'hFF, 6);
    send_byte(8'd0, 25'h1, 8'h02, 6);
    end_dl("t7");
    check("t7 word", {port1_a, port1_ds, port1_d}, {23'd0, 2'b11, 16'h02FF});
`ifdef LOADER_CHECKSUM_EN
    check("t7 checksum", checksum, 16'h0101);
`endif
    n = 0;
    while (!rom_loaded && n < 20) begin @(negedge clk_sys); n++; end
    check("t7 rom_loaded again", rom_loaded, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
